// File: rtl/tmds_rx_channel.sv
// TMDS receive channel: finds the 10-bit symbol boundary from control tokens,
// decodes video and sync, and measures active pixels per line and lines per frame.
module tmds_rx_channel #(
   parameter int LOCK_RUN   = 8,
   parameter int SEARCH_WIN = 2048,
   parameter int LOSS_WIN   = 4096
) (
   input  logic        clock_pixel,
   input  logic        HDMI_RESET,
   input  logic [9:0]  iTMDS,
   output logic [7:0]  oData,
   output logic        oDE,
   output logic [1:0]  oCD,
   output logic        SYNC_H,
   output logic        SYNC_V,
   output logic        oLocked,
   output logic [3:0]  oOffset,
   output logic        oSlip,
   output logic [11:0] oHActive,
   output logic [11:0] oVActive
);
   localparam int WIN_W = $clog2(SEARCH_WIN);
   localparam int RUN_W = $clog2(LOCK_RUN + 1);
   localparam int GAP_W = $clog2(LOSS_WIN);
   localparam logic [11:0] CNT_MAX = 12'hFFF;

   typedef enum logic {SEARCH, LOCKED} state_t;

   state_t           state_reg;
   logic [9:0]       prev_reg;
   logic [3:0]       offset_reg;
   logic [WIN_W-1:0] win_reg;
   logic [RUN_W-1:0] run_reg;
   logic [GAP_W-1:0] gap_reg;
   logic [11:0]      pix_reg;
   logic [11:0]      lines_reg;

   logic [19:0] window;
   logic [19:0] shifted;
   logic [9:0]  aligned;
   logic        is_token;
   logic [1:0]  token_cd;
   logic [7:0]  data_d;
   logic [7:0]  data_out;
   logic        de_next;
   logic [1:0]  cd_next;
   logic [7:0]  data_next;
   logic        de_fall;
   logic        vs_rise;
   logic [11:0] lines_plus;

   // Older word sits in the low half, so bit 0 of the window is the earliest bit.
   assign window  = {iTMDS, prev_reg};
   assign shifted = window >> offset_reg;
   assign aligned = shifted[9:0];

   always_comb begin
      is_token = 1'b1;
      token_cd = 2'b00;
      case (aligned)
         10'h354: token_cd = 2'b00;
         10'h0AB: token_cd = 2'b01;
         10'h154: token_cd = 2'b10;
         10'h2AB: token_cd = 2'b11;
         default: is_token = 1'b0;
      endcase
   end

   assign data_d      = aligned[9] ? ~aligned[7:0] : aligned[7:0];
   assign data_out[0] = data_d[0];

   genvar gi;
   generate
      for (gi = 1; gi < 8; gi++) begin : g_dec
         assign data_out[gi] = aligned[8] ? (data_d[gi] ^ data_d[gi-1])
                                          : ~(data_d[gi] ^ data_d[gi-1]);
      end
   endgenerate

   always_comb begin
      de_next   = 1'b0;
      cd_next   = 2'b00;
      data_next = 8'h00;
      if (state_reg == LOCKED) begin
         if (is_token) begin
            cd_next = token_cd;
         end else begin
            de_next   = 1'b1;
            cd_next   = oCD;
            data_next = data_out;
         end
      end
   end

   assign de_fall    = oDE & ~de_next;
   assign vs_rise    = cd_next[1] & ~oCD[1];
   assign lines_plus = (de_fall && lines_reg != CNT_MAX) ? lines_reg + 12'd1 : lines_reg;

   always_ff @(posedge clock_pixel) begin
      if (HDMI_RESET) begin
         state_reg  <= SEARCH;
         prev_reg   <= 10'd0;
         offset_reg <= 4'd0;
         win_reg    <= '0;
         run_reg    <= '0;
         gap_reg    <= '0;
         pix_reg    <= 12'd0;
         lines_reg  <= 12'd0;
         oData      <= 8'h00;
         oDE        <= 1'b0;
         oCD        <= 2'b00;
         oSlip      <= 1'b0;
         oHActive   <= 12'd0;
         oVActive   <= 12'd0;
      end else begin
         prev_reg <= iTMDS;
         oDE      <= de_next;
         oCD      <= cd_next;
         oData    <= data_next;
         oSlip    <= 1'b0;
         case (state_reg)
            SEARCH: begin
               // A completed token run takes priority over a slip due the same cycle.
               if (is_token && run_reg == RUN_W'(LOCK_RUN - 1)) begin
                  state_reg <= LOCKED;
                  run_reg   <= '0;
                  win_reg   <= '0;
                  gap_reg   <= '0;
                  pix_reg   <= 12'd0;
                  lines_reg <= 12'd0;
               end else if (win_reg == WIN_W'(SEARCH_WIN - 1)) begin
                  offset_reg <= (offset_reg == 4'd9) ? 4'd0 : offset_reg + 4'd1;
                  win_reg    <= '0;
                  run_reg    <= '0;
                  oSlip      <= 1'b1;
               end else begin
                  win_reg <= win_reg + WIN_W'(1);
                  run_reg <= is_token ? run_reg + RUN_W'(1) : '0;
               end
            end
            LOCKED: begin
               if (is_token) begin
                  gap_reg <= '0;
               end else if (gap_reg == GAP_W'(LOSS_WIN - 1)) begin
                  state_reg <= SEARCH;
                  gap_reg   <= '0;
                  win_reg   <= '0;
                  run_reg   <= '0;
               end else begin
                  gap_reg <= gap_reg + GAP_W'(1);
               end

               if (de_next) begin
                  pix_reg <= (pix_reg == CNT_MAX) ? CNT_MAX : pix_reg + 12'd1;
               end else if (de_fall) begin
                  oHActive <= pix_reg;
                  pix_reg  <= 12'd0;
               end

               if (vs_rise) begin
                  oVActive  <= lines_plus;
                  lines_reg <= 12'd0;
               end else begin
                  lines_reg <= lines_plus;
               end
            end
            default: state_reg <= SEARCH;
         endcase
      end
   end

   assign oLocked = (state_reg == LOCKED);
   assign oOffset = offset_reg;
   assign SYNC_H  = ~oCD[0];
   assign SYNC_V  = ~oCD[1];
endmodule

// File: tb/tb_tmds_rx_channel.sv
// Directed testbench for tmds_rx_channel: lock, decode, sync, measurement, loss and bit slip.
module tb_tmds_rx_channel;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  tmds = 10'd0;
   logic [7:0]  o_data;
   logic        o_de;
   logic [1:0]  o_cd;
   logic        sync_h;
   logic        sync_v;
   logic        o_locked;
   logic [3:0]  o_offset;
   logic        o_slip;
   logic [11:0] o_hactive;
   logic [11:0] o_vactive;

   int checks = 0;
   int errors = 0;

   tmds_rx_channel dut (
      .clock_pixel(clk),
      .HDMI_RESET (rst),
      .iTMDS      (tmds),
      .oData      (o_data),
      .oDE        (o_de),
      .oCD        (o_cd),
      .SYNC_H     (sync_h),
      .SYNC_V     (sync_v),
      .oLocked    (o_locked),
      .oOffset    (o_offset),
      .oSlip      (o_slip),
      .oHActive   (o_hactive),
      .oVActive   (o_vactive)
   );

   always #5 clk = ~clk;

   // Present one word, let one edge pass, then settle 1 time unit past it.
   task automatic send(input logic [9:0] w);
      tmds = w;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [9:0] w);
      rst = 1'b1;
      send(w);
      send(w);
      rst = 1'b0;
   endtask

   task automatic send_lines(input int nlines, input int npix);
      repeat (4) send(10'h154);
      repeat (4) send(10'h354);
      for (int l = 0; l < nlines; l++) begin
         repeat (npix) send(10'h100);
         repeat (6) send(10'h354);
      end
   endtask

   task automatic test_reset();
      logic [42:0] got;
      logic [42:0] exp;
      do_reset(10'h354);
      got = {o_data, o_de, o_cd, sync_h, sync_v, o_locked, o_slip, o_offset, o_hactive, o_vactive};
      exp = {8'h00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 12'd0, 12'd0};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL reset_state: got %h expected %h", got, exp);
      end
      $display("test_reset done");
   endtask

   task automatic test_aligned_lock();
      do_reset(10'h000);
      repeat (8) send(10'h354);
      checks++;
      if (o_locked !== 1'b0) begin
         errors++;
         $display("FAIL lock_early: oLocked=%b expected 0", o_locked);
      end
      send(10'h100);
      checks++;
      if ({o_locked, o_de} !== 2'b10) begin
         errors++;
         $display("FAIL lock_after_run: {oLocked,oDE}=%b expected 10", {o_locked, o_de});
      end
      send(10'h2FF);
      checks++;
      if ({o_de, o_data} !== {1'b1, 8'h00}) begin
         errors++;
         $display("FAIL data_100: oDE=%b oData=%h expected 1/00", o_de, o_data);
      end
      send(10'h354);
      checks++;
      if ({o_de, o_data} !== {1'b1, 8'hFE}) begin
         errors++;
         $display("FAIL data_2FF: oDE=%b oData=%h expected 1/fe", o_de, o_data);
      end
      send(10'h354);
      checks++;
      if ({o_de, o_data, o_cd, o_slip, o_offset} !== {1'b0, 8'h00, 2'b00, 1'b0, 4'd0}) begin
         errors++;
         $display("FAIL token_after_data: oDE=%b oData=%h oCD=%b oSlip=%b oOffset=%0d expected 0/00/00/0/0",
                  o_de, o_data, o_cd, o_slip, o_offset);
      end
      $display("test_aligned_lock done");
   endtask

   task automatic test_sync_decode();
      send(10'h0AB);
      send(10'h154);
      checks++;
      if ({o_cd, sync_h, sync_v} !== 4'b0101) begin
         errors++;
         $display("FAIL cd_01: oCD=%b SYNC_H=%b SYNC_V=%b expected 01/0/1", o_cd, sync_h, sync_v);
      end
      send(10'h2AB);
      checks++;
      if ({o_cd, sync_h, sync_v} !== 4'b1010) begin
         errors++;
         $display("FAIL cd_10: oCD=%b SYNC_H=%b SYNC_V=%b expected 10/1/0", o_cd, sync_h, sync_v);
      end
      send(10'h1A5);
      checks++;
      if ({o_cd, sync_h, sync_v, o_de} !== 5'b11000) begin
         errors++;
         $display("FAIL cd_11: oCD=%b SYNC_H=%b SYNC_V=%b oDE=%b expected 11/0/0/0", o_cd, sync_h, sync_v, o_de);
      end
      send(10'h0F0);
      checks++;
      if ({o_de, o_data, o_cd} !== {1'b1, 8'hEF, 2'b11}) begin
         errors++;
         $display("FAIL data_1A5_cd_hold: oDE=%b oData=%h oCD=%b expected 1/ef/11", o_de, o_data, o_cd);
      end
      send(10'h354);
      checks++;
      if ({o_de, o_data, o_cd} !== {1'b1, 8'hEE, 2'b11}) begin
         errors++;
         $display("FAIL data_0F0: oDE=%b oData=%h oCD=%b expected 1/ee/11", o_de, o_data, o_cd);
      end
      send(10'h354);
      checks++;
      if ({o_de, o_cd, sync_h, sync_v} !== 5'b00011) begin
         errors++;
         $display("FAIL cd_00: oDE=%b oCD=%b SYNC_H=%b SYNC_V=%b expected 0/00/1/1", o_de, o_cd, sync_h, sync_v);
      end
      $display("test_sync_decode done");
   endtask

   task automatic test_mode_measure();
      do_reset(10'h354);
      repeat (10) send(10'h354);
      send_lines(10, 854);
      checks++;
      if ({o_hactive, o_vactive} !== {12'd854, 12'd0}) begin
         errors++;
         $display("FAIL first_frame: oHActive=%0d oVActive=%0d expected 854/0", o_hactive, o_vactive);
      end
      send_lines(7, 640);
      checks++;
      if ({o_hactive, o_vactive} !== {12'd640, 12'd10}) begin
         errors++;
         $display("FAIL second_frame: oHActive=%0d oVActive=%0d expected 640/10", o_hactive, o_vactive);
      end
      repeat (4) send(10'h154);
      repeat (2) send(10'h354);
      checks++;
      if ({o_hactive, o_vactive} !== {12'd640, 12'd7}) begin
         errors++;
         $display("FAIL third_vsync: oHActive=%0d oVActive=%0d expected 640/7", o_hactive, o_vactive);
      end
      $display("test_mode_measure done");
   endtask

   task automatic test_loss_of_lock();
      repeat (2) send(10'h354);
      repeat (4096) send(10'h100);
      checks++;
      if (o_locked !== 1'b1) begin
         errors++;
         $display("FAIL loss_early: oLocked=%b expected 1", o_locked);
      end
      send(10'h100);
      checks++;
      if ({o_locked, o_de} !== 2'b01) begin
         errors++;
         $display("FAIL loss_edge: {oLocked,oDE}=%b expected 01", {o_locked, o_de});
      end
      send(10'h100);
      checks++;
      if ({o_de, o_data, o_cd, o_hactive, o_vactive} !== {1'b0, 8'h00, 2'b00, 12'd640, 12'd7}) begin
         errors++;
         $display("FAIL loss_outputs: oDE=%b oData=%h oCD=%b oHActive=%0d oVActive=%0d expected 0/00/00/640/7",
                  o_de, o_data, o_cd, o_hactive, o_vactive);
      end
      repeat (8) send(10'h354);
      checks++;
      if (o_locked !== 1'b0) begin
         errors++;
         $display("FAIL relock_early: oLocked=%b expected 0", o_locked);
      end
      send(10'h354);
      checks++;
      if ({o_locked, o_offset, o_hactive} !== {1'b1, 4'd0, 12'd640}) begin
         errors++;
         $display("FAIL relock: oLocked=%b oOffset=%0d oHActive=%0d expected 1/0/640", o_locked, o_offset, o_hactive);
      end
      $display("test_loss_of_lock done");
   endtask

   task automatic test_reset_mid_lock();
      repeat (5) send(10'h100);
      repeat (2) send(10'h354);
      checks++;
      if (o_hactive !== 12'd5) begin
         errors++;
         $display("FAIL short_line: oHActive=%0d expected 5", o_hactive);
      end
      repeat (3) send(10'h100);
      rst = 1'b1;
      send(10'h100);
      checks++;
      if ({o_locked, o_de, sync_h, sync_v, o_offset, o_hactive} !== {1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 12'd0}) begin
         errors++;
         $display("FAIL reset_mid_lock: oLocked=%b oDE=%b SYNC_H=%b SYNC_V=%b oOffset=%0d oHActive=%0d expected 0/0/1/1/0/0",
                  o_locked, o_de, sync_h, sync_v, o_offset, o_hactive);
      end
      rst = 1'b0;
      $display("test_reset_mid_lock done");
   endtask

   task automatic test_bit_slip();
      int slips;
      int lock_edge;
      slips     = 0;
      lock_edge = 0;
      // 10'h354 repeated and delayed by 3 bit times arrives rotated as 10'h2A6.
      do_reset(10'h2A6);
      for (int e = 1; e <= 6200; e++) begin
         send(10'h2A6);
         if (o_slip === 1'b1) begin
            slips++;
            checks++;
            if (e !== 2048 * slips) begin
               errors++;
               $display("FAIL slip_time: slip %0d at edge %0d expected edge %0d", slips, e, 2048 * slips);
            end
         end
         if (o_locked === 1'b1 && lock_edge == 0) lock_edge = e;
      end
      checks++;
      if (slips !== 3) begin
         errors++;
         $display("FAIL slip_count: %0d slips expected 3", slips);
      end
      checks++;
      if ({o_offset, o_de, o_data, o_cd} !== {4'd3, 1'b0, 8'h00, 2'b00}) begin
         errors++;
         $display("FAIL slip_offset: oOffset=%0d oDE=%b oData=%h oCD=%b expected 3/0/00/00", o_offset, o_de, o_data, o_cd);
      end
      checks++;
      if (lock_edge !== 6152) begin
         errors++;
         $display("FAIL slip_lock_edge: locked at edge %0d expected 6152", lock_edge);
      end
      rst = 1'b1;
      send(10'h2A6);
      checks++;
      if ({o_offset, o_locked} !== {4'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_offset: oOffset=%0d oLocked=%b expected 0/0", o_offset, o_locked);
      end
      rst = 1'b0;
      $display("test_bit_slip done");
   endtask

   initial begin
      test_reset();
      test_aligned_lock();
      test_sync_decode();
      test_mode_measure();
      test_loss_of_lock();
      test_reset_mid_lock();
      test_bit_slip();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
